ula_multiciclo: RTL and testbench

Parametrised, registered successor to the single-cycle ALU, sitting in the EX stage of the multicycle datapath.
- Executes the existing 16 shift/arith/logic/lui/ori ops with a 1-cycle registered latency.
- Corrects arithmetic-shift, signed-compare and nor semantics from the single-cycle version.
- Adds iterative mult/multu/div/divu with internal HI/LO registers, plus mfhi/mflo reads.
- Uses a start/busy/done handshake toward the control FSM.

---
 rtl/ula_multiciclo_if.sv | 32 +++
 rtl/ula_multiciclo.sv | 213 +++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ula_multiciclo_if.sv
// ALU handshake and operand bus between the multicycle control FSM and the ALU.
interface ula_multiciclo_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [4:0]       OP;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [SHW-1:0]   shamt;
  logic [IMM_W-1:0] immediate;
  logic             bne;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             Zero_flag;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, OP, In1, In2, shamt, immediate, bne,
    input  busy, done, result, Zero_flag, hi, lo, div_by_zero
  );

  modport slave (
    input  start, OP, In1, In2, shamt, immediate, bne,
    output busy, done, result, Zero_flag, hi, lo, div_by_zero
  );
endinterface

// File: rtl/ula_multiciclo.sv
// Registered multicycle ALU: single-cycle shift/arith/logic ops plus iterative
// mult/multu/div/divu with HI/LO, start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// ITER  | one shift-add / restoring-subtract step per cycle on magnitudes
// FIX   | apply signs to product or quotient/remainder
// DONE  | done pulse, result/hi/lo valid; a new start may be accepted
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ula_multiciclo_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   alu_res;
  logic [SHW-1:0]     shv;
  logic               op_sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Single-cycle operation result, computed from the live bus at acceptance.
  always_comb begin
    shv = bus.In1[SHW-1:0];
    alu_res = '0;
    case (bus.OP)
      5'd0:  alu_res = bus.In2 << bus.shamt;
      5'd1:  alu_res = bus.In2 >> bus.shamt;
      5'd2:  alu_res = $signed(bus.In2) >>> bus.shamt;
      5'd3:  alu_res = bus.In2 << shv;
      5'd4:  alu_res = bus.In2 >> shv;
      5'd5:  alu_res = $signed(bus.In2) >>> shv;
      5'd6:  alu_res = bus.In1 + bus.In2;
      5'd7:  alu_res = bus.In1 - bus.In2;
      5'd8:  alu_res = bus.In1 & bus.In2;
      5'd9:  alu_res = bus.In1 | bus.In2;
      5'd10: alu_res = bus.In1 ^ bus.In2;
      5'd11: alu_res = ~(bus.In1 | bus.In2);
      5'd12: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.In1) < $signed(bus.In2))};
      5'd13: alu_res = {{(WIDTH-1){1'b0}}, (bus.In1 < bus.In2)};
      5'd14: alu_res = {bus.immediate, {(WIDTH-IMM_W){1'b0}}};
      5'd15: alu_res = bus.In1 | {{(WIDTH-IMM_W){1'b0}}, bus.immediate};
      5'd20: alu_res = hi_q;
      5'd21: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Datapath helpers: operand magnitudes, one iteration step, sign fix-up.
  always_comb begin
    op_sgn   = (bus.OP == 5'd16) || (bus.OP == 5'd18);
    abs_a    = (op_sgn && bus.In1[WIDTH-1]) ? -bus.In1 : bus.In1;
    abs_b    = (op_sgn && bus.In2[WIDTH-1]) ? -bus.In2 : bus.In2;
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_b_q};
    prod     = {acc_hi_q, acc_lo_q};
    prod_s   = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_s    = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
    rem_s    = neg_a_q ? -acc_hi_q : acc_hi_q;
  end

  // Next-state and next-output logic for the control FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mag_b_d  = mag_b_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          if (bus.OP >= 5'd16 && bus.OP <= 5'd19) begin
            if (bus.OP[1] && bus.In2 == '0) begin
              // Divide by zero bypasses iteration entirely.
              state_d  = S_DONE;
              done_d   = 1'b1;
              lo_d     = '1;
              hi_d     = bus.In1;
              result_d = '1;
              dbz_d    = 1'b1;
            end else begin
              state_d  = S_ITER;
              busy_d   = 1'b1;
              cnt_d    = SHW'(WIDTH-1);
              is_div_d = bus.OP[1];
              neg_a_d  = op_sgn && bus.In1[WIDTH-1];
              neg_b_d  = op_sgn && bus.In2[WIDTH-1];
              acc_hi_d = '0;
              // mult: multiplier shifts out of acc_lo; div: dividend does.
              acc_lo_d = bus.OP[1] ? abs_a : abs_b;
              mag_b_d  = bus.OP[1] ? abs_b : abs_a;
            end
          end else begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = alu_res;
            dbz_d    = 1'b0;
          end
        end
      end
      S_ITER: begin
        if (is_div_q) begin
          if (div_sh >= {1'b0, mag_b_q}) begin
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        if (is_div_q) begin
          hi_d     = rem_s;
          lo_d     = quo_s;
          result_d = quo_s;
        end else begin
          hi_d     = prod_s[2*WIDTH-1:WIDTH];
          lo_d     = prod_s[WIDTH-1:0];
          result_d = prod_s[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mag_b_q  <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mag_b_q  <= mag_b_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.Zero_flag   = bus.bne ? (result_q != '0) : (result_q == '0);
endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo: directed cases plus random ops against a
// plain-arithmetic reference model.
module tb_ula_multiciclo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  ula_multiciclo_if #(.WIDTH(32), .IMM_W(16)) bus ();
  ula_multiciclo #(.WIDTH(32), .IMM_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: result, new hi/lo, div-by-zero flag and done latency.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [15:0] imm,
                       output logic [31:0] r, output logic [31:0] nh, output logic [31:0] nl,
                       output logic dz, output int lat);
    longint sa, sb, q, rm, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nh = m_hi; nl = m_lo; dz = 1'b0; lat = 1; r = '0;
    case (op)
      5'd0:  r = b << sh;
      5'd1:  r = b >> sh;
      5'd2:  r = $signed(b) >>> sh;
      5'd3:  r = b << a[4:0];
      5'd4:  r = b >> a[4:0];
      5'd5:  r = $signed(b) >>> a[4:0];
      5'd6:  r = a + b;
      5'd7:  r = a - b;
      5'd8:  r = a & b;
      5'd9:  r = a | b;
      5'd10: r = a ^ b;
      5'd11: r = ~(a | b);
      5'd12: r = (sa < sb) ? 32'd1 : 32'd0;
      5'd13: r = (a < b) ? 32'd1 : 32'd0;
      5'd14: r = {imm, 16'h0};
      5'd15: r = a | {16'h0, imm};
      5'd16: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; r = nl; lat = 34; end
      5'd17: begin p = longint'({32'h0, a}) * longint'({32'h0, b}); nh = p[63:32]; nl = p[31:0]; r = nl; lat = 34; end
      5'd18, 5'd19: begin
        if (b == 0) begin
          nl = 32'hFFFFFFFF; nh = a; dz = 1'b1; r = nl;
        end else if (op == 5'd18) begin
          q = sa / sb; rm = sa % sb;
          nl = q[31:0]; nh = rm[31:0]; r = nl; lat = 34;
        end else begin
          nl = a / b; nh = a % b; r = nl; lat = 34;
        end
      end
      5'd20: r = m_hi;
      5'd21: r = m_lo;
      default: r = '0;
    endcase
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [15:0] imm, input logic bn, input int inj);
    logic [31:0] er, eh, el;
    logic ed;
    int elat, lat, bcnt;
    model(op, a, b, sh, imm, er, eh, el, ed, elat);
    @(negedge clk);
    bus.OP = op; bus.In1 = a; bus.In2 = b; bus.shamt = sh; bus.immediate = imm;
    bus.bne = bn; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      if (inj != 0 && lat == inj) begin
        bus.OP = 5'd6; bus.In1 = 32'h1111; bus.In2 = 32'h2222; bus.start = 1'b1;
      end
      if (inj != 0 && lat == inj + 1) bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency op%0d", op), 32'(lat), 32'(elat));
    chk($sformatf("busy_cycles op%0d", op), 32'(bcnt), (elat == 34) ? 32'd33 : 32'd0);
    chk($sformatf("result op%0d", op), bus.result, er);
    chk($sformatf("hi op%0d", op), bus.hi, eh);
    chk($sformatf("lo op%0d", op), bus.lo, el);
    chk($sformatf("dbz op%0d", op), 32'(bus.div_by_zero), 32'(ed));
    chk($sformatf("zero_flag op%0d", op), 32'(bus.Zero_flag), 32'(bn ? (er != 0) : (er == 0)));
    m_hi = eh; m_lo = el;
    if (inj != 0) begin
      @(posedge clk); #1;
      chk("ignored_start_no_done", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    int lat, dcnt;
    logic [4:0] rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.OP = '0; bus.In1 = '0; bus.In2 = '0;
    bus.shamt = '0; bus.immediate = '0; bus.bne = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    chk("rst_zero_flag", 32'(bus.Zero_flag), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // shifts and compares
    do_op(5'd2,  32'h0, 32'hF0000000, 5'd4, 16'h0, 1'b0, 0);
    do_op(5'd1,  32'h0, 32'hF0000000, 5'd4, 16'h0, 1'b0, 0);
    do_op(5'd12, 32'hFFFFFFFF, 32'd1, 5'd0, 16'h0, 1'b0, 0);
    do_op(5'd13, 32'hFFFFFFFF, 32'd1, 5'd0, 16'h0, 1'b0, 0);
    do_op(5'd13, 32'hFFFFFFFF, 32'd1, 5'd0, 16'h0, 1'b1, 0);
    do_op(5'd11, 32'h0F0F0000, 32'h000000FF, 5'd0, 16'h0, 1'b0, 0);
    // mul / div
    do_op(5'd16, 32'hFFFFFFFD, 32'd7, 5'd0, 16'h0, 1'b0, 0);
    do_op(5'd17, 32'hFFFFFFFF, 32'd2, 5'd0, 16'h0, 1'b0, 0);
    do_op(5'd18, 32'hFFFFFFF9, 32'd2, 5'd0, 16'h0, 1'b0, 0);
    do_op(5'd19, 32'd7, 32'd0, 5'd0, 16'h0, 1'b0, 0);
    do_op(5'd20, 32'd0, 32'd0, 5'd0, 16'h0, 1'b0, 0);
    do_op(5'd18, 32'h80000000, 32'hFFFFFFFF, 5'd0, 16'h0, 1'b0, 0);
    // immediates and unused opcode
    do_op(5'd14, 32'h0, 32'h0, 5'd0, 16'h1234, 1'b0, 0);
    do_op(5'd15, 32'h00FF0000, 32'h0, 5'd0, 16'h00AA, 1'b0, 0);
    do_op(5'd25, 32'h12345678, 32'h9ABCDEF0, 5'd3, 16'h5555, 1'b0, 0);

    // start while busy is ignored
    do_op(5'd16, 32'h00012345, 32'hFFFF0003, 5'd0, 16'h0, 1'b0, 4);

    // reset in the middle of an iteration
    @(negedge clk);
    bus.OP = 5'd16; bus.In1 = 32'd1000; bus.In2 = 32'd1000; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);

    // random ops against the model
    for (int i = 0; i < 60; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(0, 9));
        default: ;
      endcase
      do_op(rop, ra, rb, 5'($urandom), 16'($urandom), 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
